// File: rtl/imm_queue.sv
// Circular immediate store: decode allocates one LANES-wide group at the tail, commit frees from the head,
// and issue reads individual slots through RPORTS combinational ports.
module imm_queue #(
    parameter int WIDTH      = 32,
    parameter int WIDTH_ADDR = 5,
    parameter int LANES      = 4,
    parameter int RPORTS     = 4,
    localparam int SIZE      = 1 << WIDTH_ADDR,
    localparam int GROUPS    = SIZE / LANES,
    localparam int GW        = $clog2(GROUPS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_alloc,
    input  logic [LANES-1:0]             i_wmask,
    input  logic [LANES*WIDTH-1:0]       i_wdata,
    output logic                         o_alloc_ready,
    output logic [GW-1:0]                o_alloc_idx,
    input  logic                         i_free,
    output logic                         o_empty,
    output logic [GW:0]                  o_count,
    input  logic [RPORTS*WIDTH_ADDR-1:0] i_raddr,
    output logic [RPORTS*WIDTH-1:0]      o_rdata,
    output logic [RPORTS-1:0]            o_rvalid
);

    logic [GW:0]       r_head;
    logic [GW:0]       r_tail;
    logic [SIZE-1:0]   r_valid;
    logic [WIDTH-1:0]  r_data [SIZE];

    logic              w_empty;
    logic              w_full;
    logic              w_do_alloc;
    logic              w_do_free;

    // Pointers carry a wrap bit so equal indices distinguish empty from full.
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (r_head[GW-1:0] == r_tail[GW-1:0]) && (r_head[GW] != r_tail[GW]);
    assign w_do_alloc = i_alloc && !w_full;
    assign w_do_free  = i_free && !w_empty;

    assign o_alloc_ready = !w_full;
    assign o_empty       = w_empty;
    assign o_count       = r_tail - r_head;
    assign o_alloc_idx   = r_tail[GW-1:0];

    // Head/tail pointer update; flush wins over alloc and free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= w_do_free  ? r_head + 1'b1 : r_head;
            r_tail <= w_do_alloc ? r_tail + 1'b1 : r_tail;
        end
    end

    // Per-slot live flags: alloc group loads the lane mask, freed group clears.
    // Alloc and free never target the same group, since that needs full or empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else begin
            for (int g = 0; g < GROUPS; g++) begin
                for (int k = 0; k < LANES; k++) begin
                    if (w_do_alloc && (r_tail[GW-1:0] == GW'(g))) begin
                        r_valid[g*LANES+k] <= i_wmask[k];
                    end else if (w_do_free && (r_head[GW-1:0] == GW'(g))) begin
                        r_valid[g*LANES+k] <= 1'b0;
                    end else begin
                        r_valid[g*LANES+k] <= r_valid[g*LANES+k];
                    end
                end
            end
        end
    end

    // Immediate storage, intentionally without reset; masked-off lanes keep old contents.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_do_alloc && !i_flush && i_wmask[k]) begin
                r_data[{r_tail[GW-1:0], k[$clog2(LANES)-1:0]}] <= i_wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    // Random read ports; dead slots return zero data.
    always_comb begin
        o_rdata  = '0;
        o_rvalid = '0;
        for (int p = 0; p < RPORTS; p++) begin
            if (r_valid[i_raddr[p*WIDTH_ADDR +: WIDTH_ADDR]]) begin
                o_rvalid[p]             = 1'b1;
                o_rdata[p*WIDTH +: WIDTH] = r_data[i_raddr[p*WIDTH_ADDR +: WIDTH_ADDR]];
            end else begin
                o_rvalid[p]             = 1'b0;
                o_rdata[p*WIDTH +: WIDTH] = '0;
            end
        end
    end

endmodule

// File: tb/tb_imm_queue.sv
// Directed bench for imm_queue: fill/wrap, full and empty corner cases, sparse masks, flush and async reset.
module tb_imm_queue;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          alloc;
    logic [3:0]    wmask;
    logic [127:0]  wdata;
    logic          alloc_ready;
    logic [2:0]    alloc_idx;
    logic          free;
    logic          empty;
    logic [3:0]    count;
    logic [19:0]   raddr;
    logic [127:0]  rdata;
    logic [3:0]    rvalid;

    int n_cmp;
    int n_err;

    imm_queue dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_alloc(alloc),
        .i_wmask(wmask), .i_wdata(wdata), .o_alloc_ready(alloc_ready),
        .o_alloc_idx(alloc_idx), .i_free(free), .o_empty(empty), .o_count(count),
        .i_raddr(raddr), .o_rdata(rdata), .o_rvalid(rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] lanes(input logic [31:0] base);
        logic [127:0] v;
        for (int k = 0; k < 4; k++) v[k*32 +: 32] = base + 32'(k);
        return v;
    endfunction

    // One clock with the given controls, then controls drop back to idle.
    task automatic cycle(input logic a, input logic f, input logic fl, input logic [3:0] m, input logic [127:0] d);
        alloc = a; free = f; flush = fl; wmask = m; wdata = d;
        @(posedge clk); #1;
        alloc = 1'b0; free = 1'b0; flush = 1'b0; wmask = 4'h0; wdata = 128'h0;
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
        raddr = {a3, a2, a1, a0};
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; alloc = 1'b0; free = 1'b0; wmask = 4'h0; wdata = 128'h0; raddr = 20'h0;
        #2;
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (alloc_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", alloc_idx); end
        n_cmp++; if (rvalid !== 4'h0) begin n_err++; $display("FAIL reset_rvalid: got %h want 0", rvalid); end
        n_cmp++; if (rdata !== 128'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill;
        for (int g = 0; g < 8; g++) begin
            n_cmp++; if (alloc_idx !== 3'(g)) begin n_err++; $display("FAIL fill_idx: got %0d want %0d", alloc_idx, g); end
            cycle(1'b1, 1'b0, 1'b0, 4'hF, lanes(32'h100 * 32'(g)));
        end
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d want 8", count); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", alloc_ready); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty: got %b want 0", empty); end
        set_reads(5'd13, 5'd0, 5'd31, 5'd6);
        n_cmp++; if (rvalid !== 4'hF) begin n_err++; $display("FAIL fill_rvalid: got %h want f", rvalid); end
        n_cmp++; if (rdata[31:0] !== 32'h301) begin n_err++; $display("FAIL fill_slot13: got %h want 301", rdata[31:0]); end
        n_cmp++; if (rdata[63:32] !== 32'h000) begin n_err++; $display("FAIL fill_slot0: got %h want 0", rdata[63:32]); end
        n_cmp++; if (rdata[95:64] !== 32'h703) begin n_err++; $display("FAIL fill_slot31: got %h want 703", rdata[95:64]); end
        n_cmp++; if (rdata[127:96] !== 32'h102) begin n_err++; $display("FAIL fill_slot6: got %h want 102", rdata[127:96]); end
    endtask

    task automatic test_full_alloc;
        cycle(1'b1, 1'b0, 1'b0, 4'hF, lanes(32'hDEAD0000));
        set_reads(5'd0, 5'd1, 5'd2, 5'd3);
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", count); end
        n_cmp++; if (alloc_idx !== 3'd0) begin n_err++; $display("FAIL full_idx: got %0d want 0", alloc_idx); end
        n_cmp++; if (rdata !== {32'h3, 32'h2, 32'h1, 32'h0}) begin n_err++; $display("FAIL full_data: got %h want group0 unchanged", rdata); end
    endtask

    task automatic test_alloc_free_full;
        cycle(1'b1, 1'b1, 1'b0, 4'hF, lanes(32'hAAAA0000));
        set_reads(5'd0, 5'd1, 5'd2, 5'd3);
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL af_full_count: got %0d want 7", count); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL af_full_ready: got %b want 1", alloc_ready); end
        n_cmp++; if (rvalid !== 4'h0) begin n_err++; $display("FAIL af_full_rvalid: got %h want 0", rvalid); end
        n_cmp++; if (alloc_idx !== 3'd0) begin n_err++; $display("FAIL af_full_idx: got %0d want 0", alloc_idx); end
        cycle(1'b1, 1'b0, 1'b0, 4'hF, lanes(32'h900));
        set_reads(5'd1, 5'd4, 5'd0, 5'd3);
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL wrap_count: got %0d want 8", count); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL wrap_ready: got %b want 0", alloc_ready); end
        n_cmp++; if (alloc_idx !== 3'd1) begin n_err++; $display("FAIL wrap_idx: got %0d want 1", alloc_idx); end
        n_cmp++; if (rdata[31:0] !== 32'h901) begin n_err++; $display("FAIL wrap_slot1: got %h want 901", rdata[31:0]); end
        n_cmp++; if (rdata[63:32] !== 32'h100) begin n_err++; $display("FAIL wrap_slot4: got %h want 100", rdata[63:32]); end
    endtask

    task automatic test_flush;
        cycle(1'b0, 1'b0, 1'b1, 4'h0, 128'h0);
        for (int g = 0; g < 3; g++) cycle(1'b1, 1'b0, 1'b0, 4'hF, lanes(32'h500 + 32'h10 * 32'(g)));
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        cycle(1'b1, 1'b0, 1'b1, 4'hF, lanes(32'hBBBB0000));
        set_reads(5'd0, 5'd5, 5'd10, 5'd12);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", empty); end
        n_cmp++; if (alloc_idx !== 3'd0) begin n_err++; $display("FAIL flush_idx: got %0d want 0", alloc_idx); end
        n_cmp++; if (rvalid !== 4'h0) begin n_err++; $display("FAIL flush_rvalid: got %h want 0", rvalid); end
    endtask

    task automatic test_alloc_free_empty;
        cycle(1'b1, 1'b1, 1'b0, 4'hF, lanes(32'h600));
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL af_empty_count: got %0d want 1", count); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL af_empty_empty: got %b want 0", empty); end
        cycle(1'b0, 1'b1, 1'b0, 4'h0, 128'h0);
        cycle(1'b0, 1'b1, 1'b0, 4'h0, 128'h0);
        set_reads(5'd0, 5'd1, 5'd2, 5'd3);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL free_empty_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL free_empty_empty: got %b want 1", empty); end
        n_cmp++; if (alloc_idx !== 3'd1) begin n_err++; $display("FAIL free_empty_idx: got %0d want 1", alloc_idx); end
        n_cmp++; if (rvalid !== 4'h0) begin n_err++; $display("FAIL free_empty_rvalid: got %h want 0", rvalid); end
    endtask

    task automatic test_sparse;
        cycle(1'b1, 1'b0, 1'b0, 4'b0101, {32'h44, 32'h33, 32'h22, 32'h11});
        set_reads(5'd4, 5'd5, 5'd6, 5'd7);
        n_cmp++; if (rvalid !== 4'b0101) begin n_err++; $display("FAIL sparse_rvalid: got %b want 0101", rvalid); end
        n_cmp++; if (rdata !== {32'h0, 32'h33, 32'h0, 32'h11}) begin n_err++; $display("FAIL sparse_rdata: got %h want 0,33,0,11", rdata); end
    endtask

    task automatic test_async_reset;
        cycle(1'b1, 1'b0, 1'b0, 4'hF, lanes(32'h700));
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL arst_pre_count: got %0d want 2", count); end
        #3;
        rst_n = 1'b0;
        #1;
        set_reads(5'd4, 5'd6, 5'd8, 5'd9);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL arst_empty: got %b want 1", empty); end
        n_cmp++; if (rvalid !== 4'h0) begin n_err++; $display("FAIL arst_rvalid: got %h want 0", rvalid); end
        n_cmp++; if (rdata !== 128'h0) begin n_err++; $display("FAIL arst_rdata: got %h want 0", rdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 1'b0, 1'b0, 4'hF, lanes(32'h800));
        set_reads(5'd0, 5'd3, 5'd4, 5'd4);
        n_cmp++; if (alloc_idx !== 3'd1) begin n_err++; $display("FAIL arst_post_idx: got %0d want 1", alloc_idx); end
        n_cmp++; if (rdata[63:0] !== {32'h803, 32'h800}) begin n_err++; $display("FAIL arst_post_data: got %h want 803_800", rdata[63:0]); end
        n_cmp++; if (rvalid !== 4'b0011) begin n_err++; $display("FAIL arst_post_rvalid: got %b want 0011", rvalid); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_full_alloc();
        test_alloc_free_full();
        test_flush();
        test_alloc_free_empty();
        test_sparse();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
